// File: rtl/saturn_phase_sequencer_pkg.sv
// rtl/saturn_phase_sequencer_pkg.sv - shared state encodings and phase constants
// Imported by the sequencer and by any datapath block decoding o_phase.
package saturn_phase_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_STEP = 2'd3
  } seq_state_e;

  localparam logic [1:0] PHASE_0    = 2'd0;
  localparam logic [1:0] PHASE_LAST = 2'd3;

  localparam int DIV_CNT_W  = 4;
  localparam int WAIT_CNT_W = 4;

  function automatic logic [3:0] phase_onehot(input logic [1:0] ph);
    return 4'b0001 << ph;
  endfunction

endpackage

// File: rtl/saturn_phase_sequencer_clk_div.sv
// rtl/saturn_phase_sequencer_clk_div.sv - free-running clock-enable divider
// Emits a registered one-clock enable every CLK_DIV clocks; never stalled.
module saturn_clk_div
  import saturn_phase_sequencer_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_clk_en
);

  localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(CLK_DIV - 1);

  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic                 clk_en_q, clk_en_d;

  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    clk_en_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d    = '0;
      clk_en_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q    <= '0;
      clk_en_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
    end
  end

  assign o_clk_en = clk_en_q;

endmodule

// File: rtl/saturn_phase_sequencer.sv
// rtl/saturn_phase_sequencer.sv - four-phase instruction sequencer with debug halt/step
// Reset asserts asynchronously; its release passes a two-flop synchronizer first.
module saturn_phase_sequencer
  import saturn_phase_sequencer_pkg::*;
#(
  parameter int CLK_DIV    = 1,
  parameter int RESET_WAIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_bus_busy,
  input  logic        i_halt_req,
  input  logic        i_step_req,
  output logic        o_clk_en,
  output logic [3:0]  o_phases,
  output logic [1:0]  o_phase,
  output logic [31:0] o_cycle_ctr,
  output logic        o_halted,
  output logic        o_step_done
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(RESET_WAIT);

  logic rst_meta_q, rst_sync_q;
  logic rst_int_n;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign rst_int_n = rst_sync_q;

  logic clk_en;

  saturn_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .i_clk    (i_clk),
    .i_rst_n  (rst_int_n),
    .o_clk_en (clk_en)
  );

  seq_state_e            state_q, state_d;
  logic [1:0]            phase_q, phase_d;
  logic [31:0]           cycle_ctr_q, cycle_ctr_d;
  logic [WAIT_CNT_W-1:0] wait_q, wait_d;
  logic                  halted_q, halted_d;
  logic                  step_done_q, step_done_d;
  logic                  advance;
  logic                  cycle_end;

  always_ff @(posedge i_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= ST_WAIT;
      phase_q     <= PHASE_0;
      cycle_ctr_q <= '0;
      wait_q      <= WAIT_INIT;
      halted_q    <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cycle_ctr_q <= cycle_ctr_d;
      wait_q      <= wait_d;
      halted_q    <= halted_d;
      step_done_q <= step_done_d;
    end
  end

  assign advance   = clk_en && !i_bus_busy && (state_q == ST_RUN || state_q == ST_STEP);
  assign cycle_end = advance && (phase_q == PHASE_LAST);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cycle_ctr_d = cycle_ctr_q;
    wait_d      = wait_q;
    step_done_d = 1'b0;

    if (advance) begin
      phase_d = phase_q + 2'd1;
    end
    if (cycle_end) begin
      cycle_ctr_d = cycle_ctr_q + 32'd1;
    end

    unique case (state_q)
      ST_WAIT: begin
        if (clk_en) begin
          if (wait_q <= WAIT_CNT_W'(1)) begin
            wait_d  = '0;
            state_d = i_halt_req ? ST_HALT : ST_RUN;
          end else begin
            wait_d = wait_q - 1'b1;
          end
        end
      end
      ST_RUN: begin
        // Halt is honoured only at the instruction-cycle boundary.
        if (cycle_end && i_halt_req) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (!i_halt_req) begin
          state_d = ST_RUN;
        end else if (i_step_req) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        if (cycle_end) begin
          state_d     = ST_HALT;
          step_done_d = 1'b1;
        end
      end
      default: state_d = ST_WAIT;
    endcase

    halted_d = (state_d == ST_HALT);
  end

  assign o_clk_en    = clk_en;
  assign o_phase     = phase_q;
  assign o_phases    = (state_q == ST_RUN || state_q == ST_STEP) ? phase_onehot(phase_q) : 4'b0000;
  assign o_cycle_ctr = cycle_ctr_q;
  assign o_halted    = halted_q;
  assign o_step_done = step_done_q;

endmodule
